gated_clk_en_ctrl: RTL

GATED_CLK_EN_CTRL -- requirements
Module: gated_clk_en_ctrl

---
 rtl/gated_clk_en_ctrl_if.sv | 26 ++
 rtl/gated_clk_en_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/gated_clk_en_ctrl_if.sv
// Control/status bundle between a clock-gate controller and its driver.
// The slave side is the controller; the master side drives requests and reads status.
interface gated_clk_en_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             pad_yy_test_mode;
  logic             sw_force_on;
  logic             mod_busy;
  logic             wake_req;
  logic [CNT_W-1:0] idle_thresh;
  logic             cnt_clr;
  logic             clk_en;
  logic             wake_ack;
  logic             gated;
  logic [7:0]       gate_cnt;

  modport master (
    output pad_yy_test_mode, sw_force_on, mod_busy, wake_req, idle_thresh, cnt_clr,
    input  clk_en, wake_ack, gated, gate_cnt
  );

  modport slave (
    input  pad_yy_test_mode, sw_force_on, mod_busy, wake_req, idle_thresh, cnt_clr,
    output clk_en, wake_ack, gated, gate_cnt
  );
endinterface

// File: rtl/gated_clk_en_ctrl.sv
// Idle-driven clock-gate enable controller: counts idle cycles, gates the target
// clock, and restores it on demand with a WAKE_CYC-cycle settle before wake_ack.
module gated_clk_en_ctrl #(
  parameter int WAKE_CYC = 2,  // 1..15
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  gated_clk_en_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {S_RUN, S_COUNT, S_GATED, S_WAKE} state_t;

  localparam logic [3:0] WAKE_LAST = 4'(WAKE_CYC - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_idle_cnt, w_idle_nxt;
  logic [3:0]       r_wake_cnt, w_wake_nxt;
  logic             r_wake_ack, w_ack_nxt;
  logic [7:0]       r_gate_cnt;
  logic             w_gate_entry;
  logic             w_idle;
  logic             w_wake_src;

  assign w_idle     = !bus.mod_busy && !bus.wake_req && !bus.sw_force_on &&
                      (bus.idle_thresh != '0);
  assign w_wake_src = bus.wake_req || bus.mod_busy || bus.sw_force_on;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state    <= S_RUN;
      r_idle_cnt <= '0;
      r_wake_cnt <= '0;
      r_wake_ack <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_wake_ack <= w_ack_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idle_nxt   = r_idle_cnt;
    w_wake_nxt   = r_wake_cnt;
    w_ack_nxt    = 1'b0;
    w_gate_entry = 1'b0;
    if (bus.pad_yy_test_mode) begin
      w_state_nxt = S_RUN;
      w_idle_nxt  = '0;
      w_wake_nxt  = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          w_idle_nxt = '0;
          w_wake_nxt = '0;
          if (w_idle) begin
            w_state_nxt = S_COUNT;
            w_idle_nxt  = CNT_W'(1);
          end
        end
        S_COUNT: begin
          // A threshold lowered below the running count aborts rather than wrapping.
          if (!w_idle || (r_idle_cnt > bus.idle_thresh)) begin
            w_state_nxt = S_RUN;
            w_idle_nxt  = '0;
          end else if (r_idle_cnt == bus.idle_thresh) begin
            w_state_nxt  = S_GATED;
            w_idle_nxt   = '0;
            w_gate_entry = 1'b1;
          end else begin
            w_idle_nxt = r_idle_cnt + CNT_W'(1);
          end
        end
        S_GATED: begin
          if (w_wake_src) begin
            w_state_nxt = S_WAKE;
            w_wake_nxt  = '0;
          end
        end
        S_WAKE: begin
          if (r_wake_cnt == WAKE_LAST) begin
            w_state_nxt = S_RUN;
            w_wake_nxt  = '0;
            w_ack_nxt   = 1'b1;
          end else begin
            w_wake_nxt = r_wake_cnt + 4'd1;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
          w_idle_nxt  = '0;
          w_wake_nxt  = '0;
        end
      endcase
    end
  end

  // Clear beats a simultaneous gating entry.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)                               r_gate_cnt <= '0;
    else if (bus.cnt_clr)                     r_gate_cnt <= '0;
    else if (w_gate_entry && r_gate_cnt != 8'hFF) r_gate_cnt <= r_gate_cnt + 8'd1;
  end

  assign bus.clk_en   = (r_state != S_GATED) || bus.pad_yy_test_mode;
  assign bus.gated    = (r_state == S_GATED);
  assign bus.wake_ack = r_wake_ack;
  assign bus.gate_cnt = r_gate_cnt;
endmodule
